// File: rtl/mem_lsu_split.sv
// mem_lsu_split: load/store unit that splits misaligned accesses into two aligned beats
// Ports: clk, rst_n (async, active-low)
//   req_valid/req_ready, req_opcode, req_funct3, req_addr, req_wdata : request from the pipeline
//   resp_valid, resp_rdata, resp_err                                  : one-cycle completion pulse
//   dmem_en, dmem_addr, dmem_wea, dmem_wdata, dmem_rdata              : synchronous data RAM
module mem_lsu_split #(
  parameter int XLEN          = 32,
  parameter bit MISALIGNED_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [6:0]          req_opcode,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                dmem_en,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN/8-1:0]   dmem_wea,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic [XLEN-1:0]     dmem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam logic [2:0] OWL = 3'(OW);
  typedef enum logic [2:0] {IDLE, B0, B1, WAIT, RESP, ERR} state_t;
  state_t state, state_nx;
  logic              is_load_q, split_q;
  logic [2:0]        f3_q;
  logic [OW-1:0]     off_q;
  logic [XLEN-1:0]   base_q, wdata_q, lo_q, hi_q;
  logic              ld, st, size_ok, legal, req_split;
  logic [OW-1:0]     req_off;
  logic [3:0]        sz_bytes;
  logic [2*NB-1:0]   wide_be;
  logic [2*XLEN-1:0] wide_d, wide_dm, rd_sh;
  logic [XLEN-1:0]   ext;
  logic              sb;
  assign ld        = req_opcode == 7'b0000011;
  assign st        = req_opcode == 7'b0100011;
  assign size_ok   = {1'b0, req_funct3[1:0]} <= OWL;
  // unsigned forms exist only for loads narrower than the full word
  assign legal     = size_ok && (ld ? !(req_funct3[2] && {1'b0, req_funct3[1:0]} == OWL)
                                    : st && !req_funct3[2]);
  assign req_off   = req_addr[OW-1:0];
  assign req_split = ({1'b0, req_off} + ((OW+1)'(1) << req_funct3[1:0])) > (OW+1)'(NB);
  assign sz_bytes  = 4'(1) << f3_q[1:0];
  // byte mask and data placed across two words; low half is beat0, high half beat1
  assign wide_be   = (((2*NB)'(1) << sz_bytes) - (2*NB)'(1)) << off_q;
  assign wide_d    = {XLEN'(0), wdata_q} << {off_q, 3'b0};
  assign rd_sh     = {hi_q, lo_q} >> {off_q, 3'b0};
  always_comb begin
    wide_dm = '0;
    for (int i = 0; i < 2*NB; i++) wide_dm[8*i+:8] = wide_be[i] ? wide_d[8*i+:8] : 8'h0;
  end
  always_comb begin
    ext = rd_sh[XLEN-1:0];
    sb  = !f3_q[2] && (f3_q[1:0] == 2'd0 ? rd_sh[7] : f3_q[1:0] == 2'd1 ? rd_sh[15] :
                       f3_q[1:0] == 2'd2 ? rd_sh[31] : rd_sh[XLEN-1]);
    for (int i = 0; i < NB; i++) if (i >= int'(sz_bytes)) ext[8*i+:8] = {8{sb}};
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (!legal || (req_split && !MISALIGNED_EN)) ? ERR : B0;
      B0:      state_nx = split_q ? B1 : is_load_q ? WAIT : RESP;
      B1:      state_nx = is_load_q ? WAIT : RESP;
      WAIT:    state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_load_q <= 1'b0;
      split_q   <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        is_load_q <= ld;
        split_q   <= req_split;
        f3_q      <= req_funct3;
        off_q     <= req_off;
        base_q    <= {req_addr[XLEN-1:OW], OW'(0)};
        wdata_q   <= req_wdata;
      end
      if (state == B1 && is_load_q) lo_q <= dmem_rdata;
      if (state == WAIT) begin
        if (split_q) hi_q <= dmem_rdata;
        else lo_q <= dmem_rdata;
      end
    end
  end
  assign req_ready  = state == IDLE;
  assign dmem_en    = state == B0 || state == B1;
  assign dmem_addr  = state == B0 ? base_q : state == B1 ? base_q + XLEN'(NB) : '0;
  assign dmem_wea   = is_load_q ? '0 : state == B0 ? wide_be[NB-1:0] :
                      state == B1 ? wide_be[2*NB-1:NB] : '0;
  assign dmem_wdata = is_load_q ? '0 : state == B0 ? wide_dm[XLEN-1:0] :
                      state == B1 ? wide_dm[2*XLEN-1:XLEN] : '0;
  assign resp_valid = state == RESP || state == ERR;
  assign resp_err   = state == ERR;
  assign resp_rdata = (state == RESP && is_load_q) ? ext : '0;
endmodule

// File: tb/tb_mem_lsu_split.sv
// tb_mem_lsu_split: directed bench with a byte-level reference model and per-cycle compare
module tb_mem_lsu_split;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic req_valid = 0, req_ready;
  logic [6:0] req_opcode = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_err, dmem_en;
  logic [31:0] resp_rdata, dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0] dmem_wea;
  logic r1_valid = 0, u1_ready, u1_rv, u1_err, u1_en;
  logic [6:0] r1_opcode = 0;
  logic [2:0] r1_funct3 = 0;
  logic [31:0] r1_addr = 0, r1_wdata = 0, u1_rdata, u1_addr, u1_wdata, u1_mem = 0;
  logic [3:0] u1_wea;
  mem_lsu_split #(.XLEN(32), .MISALIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_wea(dmem_wea), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata));
  mem_lsu_split #(.XLEN(32), .MISALIGNED_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(r1_valid), .req_ready(u1_ready),
    .req_opcode(r1_opcode), .req_funct3(r1_funct3), .req_addr(r1_addr), .req_wdata(r1_wdata),
    .resp_valid(u1_rv), .resp_rdata(u1_rdata), .resp_err(u1_err),
    .dmem_en(u1_en), .dmem_addr(u1_addr), .dmem_wea(u1_wea), .dmem_wdata(u1_wdata),
    .dmem_rdata(u1_mem));
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011;
  typedef struct {
    logic rdy, en; logic [31:0] addr; logic [3:0] wea; logic [31:0] wd;
    logic rv, re; logic [31:0] rd;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, resp_cyc = 0, obs_n = 0;
  logic [31:0] obs_addr[2], obs_wd[2], last_rdata;
  logic [3:0] obs_wea[2];
  logic last_err;
  logic [7:0] bmem[logic [31:0]];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] rdb(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction
  function automatic logic [31:0] rdw(input logic [31:0] a);
    return {rdb(a + 3), rdb(a + 2), rdb(a + 1), rdb(a)};
  endfunction
  task automatic setw(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) bmem[a + k] = w[8*k+:8];
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dmem_en) begin
      dmem_rdata <= rdw(dmem_addr);
      for (int k = 0; k < 4; k++) if (dmem_wea[k]) bmem[dmem_addr + k] = dmem_wdata[8*k+:8];
    end
  end
  always @(negedge clk) begin : cmp
    exp_t e;
    e = '{1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    if (q.size() > 0) e = q.pop_front();
    chk("req_ready", 32'(req_ready), 32'(e.rdy));
    chk("dmem_en", 32'(dmem_en), 32'(e.en));
    chk("dmem_addr", dmem_addr, e.addr);
    chk("dmem_wea", 32'(dmem_wea), 32'(e.wea));
    chk("dmem_wdata", dmem_wdata, e.wd);
    chk("resp_valid", 32'(resp_valid), 32'(e.rv));
    chk("resp_err", 32'(resp_err & resp_valid), 32'(e.re & e.rv));
    chk("resp_rdata", resp_rdata, e.rd);
    if (dmem_en && obs_n < 2) begin
      obs_addr[obs_n] = dmem_addr; obs_wea[obs_n] = dmem_wea; obs_wd[obs_n] = dmem_wdata; obs_n++;
    end
    if (resp_valid) begin last_rdata = resp_rdata; last_err = resp_err; resp_cyc = cyc; end
  end
  // Expected cycle-by-cycle behaviour derived from byte addresses, starting at accept+1.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e, z;
    int size;
    logic legal, split;
    logic [31:0] w0, ba, val;
    logic [3:0] wea[2];
    logic [31:0] wdb[2];
    logic [63:0] m;
    z = '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    legal = (op == LOAD && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
            (op == STORE && f3 inside {3'd0, 3'd1, 3'd2});
    size  = 1 << f3[1:0];
    split = (a % 4) + size > 4;
    w0 = a & ~32'h3;
    if (!legal) begin e = z; e.rv = 1; e.re = 1; q.push_back(e); return; end
    wea[0] = 0; wea[1] = 0; wdb[0] = 0; wdb[1] = 0;
    if (op == STORE)
      for (int k = 0; k < size; k++) begin
        ba = a + k;
        if ((ba & ~32'h3) == w0) begin wea[0][ba%4] = 1; wdb[0][8*(ba%4)+:8] = wd[8*k+:8]; end
        else begin wea[1][ba%4] = 1; wdb[1][8*(ba%4)+:8] = wd[8*k+:8]; end
      end
    for (int b = 0; b < (split ? 2 : 1); b++) begin
      e = z; e.en = 1; e.addr = w0 + 32'(4 * b); e.wea = wea[b]; e.wd = wdb[b]; q.push_back(e);
    end
    if (op == LOAD) q.push_back(z);
    val = 0;
    if (op == LOAD) begin
      for (int k = 0; k < size; k++) val[8*k+:8] = rdb(a + k);
      m = (64'd1 << (8 * size)) - 1;
      if (!f3[2] && val[8*size-1]) val = val | ~m[31:0];
    end
    e = z; e.rv = 1; e.rd = val; q.push_back(e);
  endtask
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int n;
    #1;
    req_valid = 1; req_opcode = op; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 0;
    acc_cyc = cyc - 1; obs_n = 0; resp_cyc = -100; last_err = 1'bx; last_rdata = 'x;
    build(op, f3, a, wd);
    n = 0;
    while (q.size() > 0 && n < 30) begin @(posedge clk); n++; end
    if (q.size() > 0) begin
      errors++; checks++;
      $display("FAIL timeout: %0d expected cycles left", q.size());
      q.delete();
    end
  endtask
  task automatic err1(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                      input logic exp_err);
    #1;
    r1_valid = 1; r1_opcode = op; r1_funct3 = f3; r1_addr = a; r1_wdata = 32'h1234;
    @(posedge clk);
    #1;
    r1_valid = 0;
    chk("u1_rv_t1", 32'(u1_rv), 32'(exp_err));
    chk("u1_err_t1", 32'(u1_err), 32'(exp_err));
    chk("u1_en_t1", 32'(u1_en), 32'(!exp_err));
    repeat (4) @(posedge clk);
  endtask
  initial begin
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    issue(STORE, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_beats", obs_n, 1);
    chk("sw_addr", obs_addr[0], 32'h100);
    chk("sw_wea", 32'(obs_wea[0]), 32'hF);
    chk("sw_wdata", obs_wd[0], 32'hDEADBEEF);
    chk("sw_lat", resp_cyc - acc_cyc, 2);
    issue(STORE, 3'b000, 32'h103, 32'h000000AB);
    chk("sb_beats", obs_n, 1);
    chk("sb_wea", 32'(obs_wea[0]), 32'h8);
    chk("sb_wdata", obs_wd[0], 32'hAB000000);
    chk("sb_err", 32'(last_err), 32'd0);
    setw(32'h100, 32'h80FF0000);
    issue(LOAD, 3'b000, 32'h102, 0);
    chk("lb_data", last_rdata, 32'hFFFFFFFF);
    chk("lb_lat", resp_cyc - acc_cyc, 3);
    issue(LOAD, 3'b100, 32'h102, 0);
    chk("lbu_data", last_rdata, 32'h000000FF);
    setw(32'h0FC, 32'h11223344);
    setw(32'h100, 32'h55667788);
    issue(LOAD, 3'b010, 32'h0FE, 0);
    chk("lw_split_data", last_rdata, 32'h77881122);
    chk("lw_split_lat", resp_cyc - acc_cyc, 4);
    chk("lw_split_beats", obs_n, 2);
    issue(LOAD, 3'b001, 32'h0FF, 0);
    issue(LOAD, 3'b101, 32'h0FF, 0);
    chk("lhu_split_data", last_rdata, 32'h00008811);
    issue(STORE, 3'b001, 32'h0FF, 32'h1234BEEF);
    chk("sh_b0_addr", obs_addr[0], 32'h0FC);
    chk("sh_b0_wea", 32'(obs_wea[0]), 32'h8);
    chk("sh_b0_wdata", obs_wd[0], 32'hEF000000);
    chk("sh_b1_addr", obs_addr[1], 32'h100);
    chk("sh_b1_wea", 32'(obs_wea[1]), 32'h1);
    chk("sh_b1_wdata", obs_wd[1], 32'h000000BE);
    chk("sh_lat", resp_cyc - acc_cyc, 3);
    issue(STORE, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4);
    chk("sw_wrap_b1", obs_addr[1], 32'h0);
    issue(LOAD, 3'b010, 32'hFFFFFFFE, 0);
    chk("lw_wrap_data", last_rdata, 32'hA1B2C3D4);
    issue(STORE, 3'b010, 32'h201, 32'hCAFEF00D);
    issue(LOAD, 3'b001, 32'h203, 0);
    issue(LOAD, 3'b010, 32'h201, 0);
    issue(7'h33, 3'b000, 32'h100, 0);
    chk("op33_err", 32'(last_err), 32'd1);
    chk("op33_lat", resp_cyc - acc_cyc, 1);
    issue(STORE, 3'b100, 32'h100, 0);
    issue(LOAD, 3'b110, 32'h100, 0);
    // reset asserted while the split load is in its second beat
    #1;
    req_valid = 1; req_opcode = LOAD; req_funct3 = 3'b010; req_addr = 32'h0FE;
    @(posedge clk);
    #1;
    req_valid = 0;
    build(LOAD, 3'b010, 32'h0FE, 0);
    @(posedge clk);
    #2;
    chk("b1_en_before_rst", 32'(dmem_en), 32'd1);
    rst_n = 0;
    q.delete();
    #1;
    chk("rst_en", 32'(dmem_en), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wea", 32'(dmem_wea), 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    repeat (6) @(posedge clk);
    err1(LOAD, 3'b010, 32'h102, 1'b1);
    err1(7'h33, 3'b000, 32'h100, 1'b1);
    err1(STORE, 3'b001, 32'h0FF, 1'b1);
    err1(STORE, 3'b010, 32'h200, 1'b0);
    err1(LOAD, 3'b001, 32'h102, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
